// File: rtl/param_rotator.sv
// Parametrised pattern rotator with a prescaler: steps a WIDTH-bit pattern
// once every DIV enabled cycles, either rotating circularly or bouncing end to end.
module param_rotator #(
  parameter int               WIDTH = 4,
  parameter int               DIV   = 25000,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             bounce,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] pattern,
  output logic             tick,
  output logic             wrap
);

  localparam int            CW       = ($clog2(DIV) > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0]    cnt;
  logic             bdir;
  logic             step;
  logic [WIDTH-1:0] nxt_pat;
  logic             nxt_bdir;
  logic             nxt_wrap;
  logic             lead_bit;
  logic             trail_bit;

  assign step = en && (cnt == CNT_LAST);

  // Next pattern/direction/wrap, used only on a step edge.
  always_comb begin
    nxt_pat   = pattern;
    nxt_bdir  = bounce ? bdir : dir;
    nxt_wrap  = 1'b0;
    lead_bit  = bdir ? pattern[0] : pattern[WIDTH-1];
    trail_bit = bdir ? pattern[WIDTH-1] : pattern[0];
    if (!bounce) begin
      if (!dir) begin
        nxt_pat  = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
        nxt_wrap = pattern[WIDTH-1];
      end else begin
        nxt_pat  = {pattern[0], pattern[WIDTH-1:1]};
        nxt_wrap = pattern[0];
      end
    end else if (!lead_bit) begin
      nxt_pat = bdir ? {1'b0, pattern[WIDTH-1:1]} : {pattern[WIDTH-2:0], 1'b0};
    end else if (!trail_bit) begin
      // Hit the end: reverse and move one place back the way we came.
      nxt_bdir = ~bdir;
      nxt_pat  = bdir ? {pattern[WIDTH-2:0], 1'b0} : {1'b0, pattern[WIDTH-1:1]};
      nxt_wrap = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= INIT;
      cnt     <= '0;
      bdir    <= 1'b0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else if (load) begin
      pattern <= load_val;
      cnt     <= '0;
      bdir    <= dir;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      // In rotate mode bdir tracks dir so a later switch to bounce continues that way.
      if (!bounce) bdir <= dir;
      if (step) begin
        cnt     <= '0;
        pattern <= nxt_pat;
        bdir    <= nxt_bdir;
        tick    <= 1'b1;
        wrap    <= nxt_wrap;
      end else if (en) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
